systolic_a_feeder: RTL and testbench
====================================

SYSTOLIC_A_FEEDER -- requirements
Module: systolic_a_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: width of one signed operand element.
REQ-002 The block SHALL have parameter ROWS, default 4: array rows fed, one lane per row.
REQ-003 The block SHALL have parameter DEPTH, default 16: maximum tile length K, in column vectors.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): the load handshake.
REQ-007 The block SHALL have port in_data, input, ROWS*DATA_WIDTH: one column vector, lane r at bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port in_last, input, 1 bit: marks the final vector of the tile.
REQ-009 The block SHALL have port out_ready, input, 1 bit: array advance enable; when low, the stream stalls.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_a holds a skewed stream beat.
REQ-011 The block SHALL have port out_a, output, ROWS*DATA_WIDTH: skewed operands, lane r drives array row r's a_in.
REQ-012 The block SHALL have ports out_first and out_last, output, 1 bit each: first and final beat of the tile stream.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD and STREAM.
- IDLE -> LOAD on the first accepted beat.
- LOAD -> STREAM after the beat carrying in_last, or after the DEPTH-th beat.
- STREAM -> IDLE after the out_last beat is accepted.
REQ-015 A beat SHALL be accepted when in_valid && in_ready; in_ready SHALL be 1 in IDLE and LOAD and 0 in STREAM.
REQ-016 Each accepted beat SHALL be written at column index k = 0..K-1 of the tile buffer; K is the number of accepted beats.
REQ-017 If DEPTH beats are accepted without in_last, the DEPTH-th beat SHALL terminate the tile as if in_last were set.
REQ-018 STREAM SHALL emit exactly K+ROWS-1 beats, t = 0..K+ROWS-2, with t advancing only on cycles where out_valid && out_ready.
REQ-019 On beat t, lane r SHALL carry buffer[t-r][r] when 0 <= t-r < K; otherwise it SHALL carry zero.
REQ-020 out_a, out_valid, out_first and out_last SHALL be registered; the first beat SHALL appear the cycle after the LOAD->STREAM transition.
REQ-021 While out_ready is low, out_a and all out_* flags SHALL hold their values.
REQ-022 out_first SHALL be high only on t=0; out_last SHALL be high only on t=K+ROWS-2; both SHALL be high together when K=1 and ROWS=1.
REQ-023 Data SHALL pass through unmodified: no arithmetic and no width change.
REQ-024 in_valid asserted while in STREAM SHALL have no effect on state or buffer contents.

Reset
REQ-025 While rst_n is low at a clock edge, the block SHALL set state to IDLE, K to 0, t to 0, in_ready to 0, and out_valid, out_first, out_last, busy and out_a to 0.
REQ-026 When reset is asserted mid-LOAD or mid-STREAM, the partial tile SHALL be discarded and no further out_valid beat SHALL be produced.
REQ-027 The tile buffer contents SHALL NOT be reset.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-029 When macro SA_FEEDER_PERF_CNT_EN is defined, the block SHALL add output tile_count (16 bits).
- tile_count increments on each accepted out_last beat and wraps from 0xFFFF to 0.
- tile_count resets to 0.
REQ-030 When SA_FEEDER_PERF_CNT_EN is undefined, the tile_count port and its counter SHALL be absent.

Structure
REQ-031 Package sa_pkg SHALL hold DATA_WIDTH, ROWS and DEPTH defaults, the feeder_state_t enum, and the lane-vector typedef.
REQ-032 The tile storage SHALL be a sub-module, feeder_buf: a DEPTH x ROWS*DATA_WIDTH register file with one write port and ROWS independent per-lane read addresses.

Verification (ROWS=4, DEPTH=16)
REQ-033 Tile K=3, element [c][r] = 10*(c+1)+r, out_ready held at 1:
- 6 beats are produced.
- t=0 carries [10,0,0,0]; t=2 carries [30,21,12,0]; t=5 carries [0,0,0,33].
REQ-034 Same tile with out_ready low for 2 cycles at t=2: beat t=2 holds for 3 cycles, and the total stream length is 8 cycles.
REQ-035 K=1 tile with value [5,6,7,8]:
- 4 beats are produced: [5,0,0,0], [0,6,0,0], [0,0,7,0], [0,0,0,8].
- out_first is high on the first beat and out_last on the fourth.
REQ-036 17 beats sent with no in_last: 16 are accepted, 19 beats are streamed, and in_ready stays 0 until IDLE.
REQ-037 rst_n pulsed low during stream beat t=1: the next cycle shows out_valid=0 and busy=0; a new K=2 tile then streams 5 correct beats.
REQ-038 With SA_FEEDER_PERF_CNT_EN defined, 3 back-to-back tiles leave tile_count=3.

Source files
------------

// File: rtl/systolic_a_feeder_pkg.sv
// Shared defaults and types for the systolic A-operand feeder (package sa_pkg).
package sa_pkg;

  localparam int unsigned SA_DATA_WIDTH = 16;
  localparam int unsigned SA_ROWS       = 4;
  localparam int unsigned SA_DEPTH      = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } feeder_state_t;

  typedef logic [SA_ROWS*SA_DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/systolic_a_feeder_buf.sv
// Tile register file: one full-width write port, one read address per lane.
module feeder_buf #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [ROWS*DATA_WIDTH-1:0] wr_data,
  input  logic [ROWS*AW-1:0]         rd_addr,
  output logic [ROWS*DATA_WIDTH-1:0] rd_data
);

  logic [ROWS*DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Each lane reads only its own slice, from its own column address.
  always_comb begin
    rd_data = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      rd_data[r*DATA_WIDTH +: DATA_WIDTH] =
        mem_q[rd_addr[r*AW +: AW]][r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/systolic_a_feeder.sv
// Loads a K-column tile, then streams it row-skewed into a systolic array.
// Optional macro SA_FEEDER_PERF_CNT_EN adds the tile_count output.
module systolic_a_feeder
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH,
  parameter int unsigned ROWS       = SA_ROWS,
  parameter int unsigned DEPTH      = SA_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [ROWS*DATA_WIDTH-1:0] out_a,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       busy
`ifdef SA_FEEDER_PERF_CNT_EN
  ,
  output logic [15:0]                tile_count
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned KW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(DEPTH + ROWS);
  localparam int unsigned VW = ROWS * DATA_WIDTH;

  feeder_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [TW-1:0] t_q, t_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;
  logic [VW-1:0] out_a_q, out_a_d;

  logic          wr_en;
  logic [VW-1:0] rd_data;
  logic [VW-1:0] lane_a;
  logic [ROWS*AW-1:0] rd_addr;

  feeder_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROWS      (ROWS),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(AW'(k_q)),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Lane r reads column t-r; unsigned wrap makes t<r fail the range test too.
  always_comb begin
    rd_addr = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      rd_addr[r*AW +: AW] = AW'(32'(t_q) - r);
    end
  end

  always_comb begin
    lane_a = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (32'(t_q) - r < 32'(k_q)) begin
        lane_a[r*DATA_WIDTH +: DATA_WIDTH] = rd_data[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    t_d         = t_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_a_d     = out_a_q;
    wr_en       = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (in_valid && in_ready_q) begin
          wr_en = 1'b1;
          k_d   = k_q + KW'(1);
          if (in_last || 32'(k_q) == DEPTH - 1) begin
            state_d = STREAM;
          end else begin
            state_d = LOAD;
          end
        end
      end
      STREAM: begin
        // Output register refills whenever it is empty or being consumed.
        if (!out_valid_q || out_ready) begin
          if (32'(t_q) < 32'(k_q) + ROWS - 1) begin
            out_valid_d = 1'b1;
            out_a_d     = lane_a;
            out_first_d = (t_q == '0);
            out_last_d  = (32'(t_q) == 32'(k_q) + ROWS - 2);
            t_d         = t_q + TW'(1);
          end else begin
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
          end
          if (out_valid_q && out_last_q) begin
            state_d = IDLE;
            k_d     = '0;
            t_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d != STREAM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      t_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_a_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_a_q     <= out_a_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_a     = out_a_q;
  assign busy      = (state_q != IDLE);

`ifdef SA_FEEDER_PERF_CNT_EN
  logic [15:0] tile_count_q, tile_count_d;

  always_comb begin
    tile_count_d = tile_count_q;
    if (state_q == STREAM && out_valid_q && out_ready && out_last_q) begin
      tile_count_d = tile_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_count_q <= '0;
    end else begin
      tile_count_q <= tile_count_d;
    end
  end

  assign tile_count = tile_count_q;
`endif

endmodule

// File: tb/tb_systolic_a_feeder.sv
// Scoreboard bench for systolic_a_feeder: driver pushes expected skewed beats, monitor pops.
module tb_systolic_a_feeder;

  localparam int DW    = 16;
  localparam int ROWS  = 4;
  localparam int DEPTH = 16;
  localparam int W     = ROWS * DW;

  typedef struct packed {
    logic [W-1:0] a;
    logic         first;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [W-1:0] out_a;
  logic         out_first;
  logic         out_last;
  logic         busy;
`ifdef SA_FEEDER_PERF_CNT_EN
  logic [15:0]  tile_count;
`endif

  systolic_a_feeder #(
    .DATA_WIDTH(DW),
    .ROWS      (ROWS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_a    (out_a),
    .out_first(out_first),
    .out_last (out_last),
    .busy     (busy)
`ifdef SA_FEEDER_PERF_CNT_EN
    ,
    .tile_count(tile_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  beat_t exp_q[$];
  logic [W-1:0] tile_mem [DEPTH+1];
  logic [W-1:0] acc_vec  [DEPTH];
  int valid_cyc = 0;
  int beat_idx = 0;
  int tiles_done = 0;
  int ready_mode = 0;
  int stall_left = 0;
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_a;
  logic         hold_first, hold_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: beat t, lane r carries column t-r of the tile when that column exists.
  task automatic model_push(input int k);
    beat_t b;
    for (int t = 0; t <= k + ROWS - 2; t++) begin
      b.a = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (t - r >= 0 && t - r < k) b.a[r*DW +: DW] = acc_vec[t-r][r*DW +: DW];
      end
      b.first = (t == 0);
      b.last  = (t == k + ROWS - 2);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: compares each handshaked beat and checks stalled beats stay put.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_a", out_a, hold_a);
        chk("hold_flags", {out_valid, out_first, out_last}, {1'b1, hold_first, hold_last});
        hold_pending = 1'b0;
      end
      if (out_valid) begin
        valid_cyc++;
        if (!out_ready) begin
          hold_a = out_a; hold_first = out_first; hold_last = out_last;
          hold_pending = 1'b1;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_a", out_a, e.a);
          chk("beat_first_last", {out_first, out_last}, {e.first, e.last});
          beat_idx++;
          if (out_last) begin
            beat_idx = 0;
            tiles_done++;
          end
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && beat_idx == 2 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input int n, input bit with_last, input int gap_max);
    int acc = 0;
    int wt;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        cyc();
      end
      in_valid = 1'b1;
      in_data  = tile_mem[i];
      in_last  = with_last && (i == n - 1);
      wt = 0;
      while (!in_ready && wt < 400) begin
        cyc();
        wt++;
      end
      if (!in_ready) begin
        chk("accept_timeout", 1, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      cyc();
      acc_vec[acc] = tile_mem[i];
      acc++;
      if (in_last || acc == DEPTH) begin
        model_push(acc);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int wt = 0;
    while ((busy || exp_q.size() != 0) && wt < 3000) begin
      cyc();
      wt++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic fill_k3();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < ROWS; r++) tile_mem[c][r*DW +: DW] = DW'(10 * (c + 1) + r);
  endtask

  task automatic fill_rand(input int n);
    for (int c = 0; c < n; c++) tile_mem[c] = {$urandom, $urandom};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int wt;
    bit bad;
    repeat (3) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_flags", {out_first, out_last}, 2'b00);
    rst_n = 1'b1;
    chk("in_ready_before_edge", in_ready, 0);
    cyc();
    chk("in_ready_after_rst", in_ready, 1);

    // K=3, ready held high: 6 beats
    fill_k3();
    v0 = valid_cyc;
    send_tile(3, 1'b1, 0);
    wait_drain();
    chk("k3_valid_cycles", valid_cyc - v0, 6);

    // Same tile, two stall cycles while beat t=2 is shown
    ready_mode = 2;
    stall_left = 2;
    v0 = valid_cyc;
    send_tile(3, 1'b1, 0);
    wait_drain();
    chk("k3_stall_valid_cycles", valid_cyc - v0, 8);
    ready_mode = 0;

    // K=1 tile
    tile_mem[0] = {16'd8, 16'd7, 16'd6, 16'd5};
    v0 = valid_cyc;
    send_tile(1, 1'b1, 0);
    wait_drain();
    chk("k1_valid_cycles", valid_cyc - v0, 4);

    // 17 beats without in_last: 16 accepted, 17th ignored while streaming
    fill_rand(DEPTH + 1);
    v0 = valid_cyc;
    send_tile(DEPTH, 1'b0, 0);
    in_valid = 1'b1;
    in_data  = tile_mem[DEPTH];
    bad = 1'b0;
    wt = 0;
    while (busy && wt < 200) begin
      if (in_ready) bad = 1'b1;
      cyc();
      wt++;
    end
    in_valid = 1'b0;
    chk("overflow_in_ready_low", bad, 0);
    wait_drain();
    chk("overflow_valid_cycles", valid_cyc - v0, DEPTH + ROWS - 1);

    // Reset while beat t=1 is on the output
    fill_k3();
    send_tile(3, 1'b1, 0);
    wt = 0;
    while (!(out_valid && beat_idx == 1) && wt < 100) begin
      cyc();
      wt++;
    end
    chk("reach_beat1", out_valid && beat_idx == 1, 1);
    rst_n = 1'b0;
    cyc();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    beat_idx = 0;
    tiles_done = 0;
    rst_n = 1'b1;
    cyc();
    chk("midrst_in_ready_rise", in_ready, 1);
    fill_rand(2);
    v0 = valid_cyc;
    send_tile(2, 1'b1, 0);
    wait_drain();
    chk("k2_after_rst_valid_cycles", valid_cyc - v0, 5);

    // Three back-to-back tiles
    for (int i = 0; i < 3; i++) begin
      fill_rand(4);
      send_tile(4, 1'b1, 0);
    end
    wait_drain();

    // Randomised tiles, gaps and backpressure
    ready_mode = 1;
    for (int n = 0; n < 25; n++) begin
      int k;
      k = $urandom_range(1, DEPTH);
      fill_rand(k);
      send_tile(k, (k == DEPTH) ? 1'($urandom_range(0, 1)) : 1'b1, 2);
    end
    wait_drain();
    ready_mode = 0;
    chk("tiles_since_reset", tiles_done, 29);
`ifdef SA_FEEDER_PERF_CNT_EN
    chk("tile_count", tile_count, 16'(tiles_done));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
